// File: rtl/uart_param_if.sv
// Client-side bus of uart_param: transmit valid/ready handshake and receive result.
// The client holds the master modport and the UART holds the slave modport.
interface uart_param_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              tx_done;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              rx_parity_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: start, DATA_W data bits LSB first, optional parity, STOP_BITS stops.
// Defining UART_PARITY_EN inserts and checks a parity bit (even, or odd when PARITY_ODD=1).
module uart_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_param_if.slave bus,
  output logic        tx,
  input  logic        rx
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t         tx_state, tx_state_nx;
  logic [BAUD_W-1:0] tx_baud, tx_baud_nx;
  logic [BIT_W-1:0]  tx_bit, tx_bit_nx;
  logic [DATA_W-1:0] tx_sh, tx_sh_nx;
  logic              tx_par, tx_par_nx;
  logic              tx_nx;
  logic              tx_baud_end;

  assign tx_baud_end  = (tx_baud == BAUD_LAST);
  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.tx_done  = (tx_state == TX_STOP) && tx_baud_end && (tx_bit == STOP_LAST);

  always_comb begin
    tx_state_nx = tx_state;
    tx_baud_nx  = tx_baud + 1'b1;
    tx_bit_nx   = tx_bit;
    tx_sh_nx    = tx_sh;
    tx_par_nx   = tx_par;
    unique case (tx_state)
      TX_IDLE: begin
        tx_baud_nx = '0;
        tx_bit_nx  = '0;
        if (bus.tx_valid) begin
          tx_state_nx = TX_START;
          tx_sh_nx    = bus.tx_data;
          tx_par_nx   = parity_of(bus.tx_data);
        end
      end
      TX_START: if (tx_baud_end) begin
        tx_baud_nx  = '0;
        tx_state_nx = TX_DATA;
      end
      TX_DATA: if (tx_baud_end) begin
        tx_baud_nx = '0;
        tx_sh_nx   = tx_sh >> 1;
        if (tx_bit == DATA_LAST) begin
          tx_bit_nx   = '0;
`ifdef UART_PARITY_EN
          tx_state_nx = TX_PARITY;
`else
          tx_state_nx = TX_STOP;
`endif
        end else begin
          tx_bit_nx = tx_bit + 1'b1;
        end
      end
      TX_PARITY: if (tx_baud_end) begin
        tx_baud_nx  = '0;
        tx_state_nx = TX_STOP;
      end
      TX_STOP: if (tx_baud_end) begin
        tx_baud_nx = '0;
        if (tx_bit == STOP_LAST) tx_state_nx = TX_IDLE;
        else                     tx_bit_nx   = tx_bit + 1'b1;
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  // The pin is driven from a flop, so it is decoded from the next state.
  always_comb begin
    tx_nx = 1'b1;
    case (tx_state_nx)
      TX_START:  tx_nx = 1'b0;
      TX_DATA:   tx_nx = tx_sh_nx[0];
      TX_PARITY: tx_nx = tx_par_nx;
      default:   tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_baud  <= tx_baud_nx;
      tx_bit   <= tx_bit_nx;
      tx       <= tx_nx;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh  <= tx_sh_nx;
    tx_par <= tx_par_nx;
  end

  // Receive path: rx_p0/rx_p1 synchronise, rx_p2 holds the previous value for edge detect.
  logic              rx_p0, rx_p1, rx_p2;
  rx_state_t         rx_state, rx_state_nx;
  logic [BAUD_W-1:0] rx_baud, rx_baud_nx;
  logic [BIT_W-1:0]  rx_bit, rx_bit_nx;
  logic [DATA_W-1:0] rx_sh, rx_sh_nx;
  logic              rx_ferr_acc, rx_ferr_nx;
  logic              rx_done, rx_baud_end;
  logic              rx_valid_q, rx_ferr_q;
  logic [DATA_W-1:0] rx_data_q;

  assign rx_baud_end = (rx_baud == BAUD_LAST);

  always_comb begin
    rx_state_nx = rx_state;
    rx_baud_nx  = rx_baud + 1'b1;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    rx_ferr_nx  = rx_ferr_acc;
    rx_done     = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_baud_nx = '0;
        rx_bit_nx  = '0;
        if (rx_p2 && !rx_p1) begin
          rx_state_nx = RX_START;
          rx_ferr_nx  = 1'b0;
        end
      end
      RX_START: if (rx_baud == BAUD_HALF) begin
        rx_baud_nx  = '0;
        rx_state_nx = rx_p1 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_baud_end) begin
        rx_baud_nx = '0;
        rx_sh_nx   = {rx_p1, rx_sh[DATA_W-1:1]};
        if (rx_bit == DATA_LAST) begin
          rx_bit_nx   = '0;
`ifdef UART_PARITY_EN
          rx_state_nx = RX_PARITY;
`else
          rx_state_nx = RX_STOP;
`endif
        end else begin
          rx_bit_nx = rx_bit + 1'b1;
        end
      end
      RX_PARITY: if (rx_baud_end) begin
        rx_baud_nx  = '0;
        rx_state_nx = RX_STOP;
      end
      RX_STOP: if (rx_baud_end) begin
        rx_baud_nx = '0;
        if (!rx_p1) rx_ferr_nx = 1'b1;
        if (rx_bit == STOP_LAST) begin
          rx_state_nx = RX_IDLE;
          rx_done     = 1'b1;
        end else begin
          rx_bit_nx = rx_bit + 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_p2      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_baud    <= '0;
      rx_bit     <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      rx_state   <= rx_state_nx;
      rx_baud    <= rx_baud_nx;
      rx_bit     <= rx_bit_nx;
      rx_valid_q <= rx_done;
      if (rx_done) begin
        rx_data_q <= rx_sh;
        rx_ferr_q <= rx_ferr_acc | ~rx_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    rx_sh       <= rx_sh_nx;
    rx_ferr_acc <= rx_ferr_nx;
  end

`ifdef UART_PARITY_EN
  logic rx_par_bit, rx_perr_q;

  always_ff @(posedge clk) begin
    if (rx_state == RX_PARITY && rx_baud_end) rx_par_bit <= rx_p1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       rx_perr_q <= 1'b0;
    else if (rx_done) rx_perr_q <= (parity_of(rx_sh) != rx_par_bit);
  end

  assign bus.rx_parity_err = rx_perr_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_frame_err = rx_ferr_q;
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: u1 (1 stop, odd parity option) in loopback or external rx, u2 (2 stops) on external rx.
// Expected tx waveform and received words come from a frame-level model built from the line format.
module tb_uart_param;
  localparam int C = 16;
  localparam int W = 8;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F1 = 1 + W + P + 1;
  localparam int F2 = 1 + W + P + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tx1, rx1, ext1, tx2, rx2;
  bit   loop;

  uart_param_if #(.DATA_W(W)) b1 ();
  uart_param_if #(.DATA_W(W)) b2 ();

  assign rx1 = loop ? tx1 : ext1;

  uart_param #(.DATA_W(W), .CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .tx(tx1), .rx(rx1));
  uart_param #(.DATA_W(W), .CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .tx(tx2), .rx(rx2));

  int total = 0;
  int bad   = 0;
  int mm_tx = 0, mm_done = 0, mm_rdy = 0;
  int hs_cnt = 0, done_cnt = 0, stretch = 0;
  bit mon_on = 1'b0;
  bit pv1 = 1'b0, pv2 = 1'b0;
  logic [1:0] exq[$];
  logic [9:0] got1[$];
  logic [9:0] got2[$];

  // Wire bits of one frame, index 0 = start bit; unused upper positions read as idle-high.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int stops, input bit podd,
                                             input bit flip, input int low_stop);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) f[1+i] = d[i];
    k = 1 + W;
`ifdef UART_PARITY_EN
    f[k] = (^d) ^ podd ^ flip;
    k++;
`endif
    if (low_stop >= 0 && low_stop < stops) f[k+low_stop] = 1'b0;
    return f;
  endfunction

  // Per-cycle model of u1's transmitter: each accepted word becomes F1*C expected {tx, tx_done} samples.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [1:0]  e;
      logic        rdy_m;
      logic [15:0] fb;
      rdy_m = (exq.size() == 0);
      e = 2'b10;
      if (!rdy_m) e = exq.pop_front();
      if (tx1 !== e[1]) mm_tx++;
      if (b1.tx_done !== e[0]) mm_done++;
      if (b1.tx_ready !== rdy_m) mm_rdy++;
      if (b1.tx_done === 1'b1) done_cnt++;
      if (!rst_n) begin
        exq.delete();
      end else if (b1.tx_valid && rdy_m) begin
        hs_cnt++;
        fb = frame_bits(b1.tx_data, 1, 1'b1, 1'b0, -1);
        for (int k = 0; k < F1 * C; k++) exq.push_back({fb[k/C], k == F1 * C - 1});
      end
    end
  end

  always @(negedge clk) begin
    if (b1.rx_valid === 1'b1) begin
      got1.push_back({b1.rx_parity_err, b1.rx_frame_err, b1.rx_data});
      if (pv1) stretch++;
    end
    if (b2.rx_valid === 1'b1) begin
      got2.push_back({b2.rx_parity_err, b2.rx_frame_err, b2.rx_data});
      if (pv2) stretch++;
    end
    pv1 = (b1.rx_valid === 1'b1);
    pv2 = (b2.rx_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pop(input int which);
    logic [9:0] v;
    v = 'x;
    if (which == 1 && got1.size() > 0) v = got1.pop_front();
    if (which == 2 && got2.size() > 0) v = got2.pop_front();
    return v;
  endfunction

  task automatic send1(input logic [7:0] d);
    int n;
    n = 0;
    while (b1.tx_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, b1.tx_ready}, 32'd1);
    b1.tx_valid = 1'b1;
    b1.tx_data  = d;
    tick();
    b1.tx_valid = 1'b0;
    b1.tx_data  = 8'($urandom);
  endtask

  task automatic wait_rx(input int which, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (((which == 1) ? got1.size() : got2.size()) < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, (which == 1) ? got1.size() : got2.size(), n);
  endtask

  task automatic drive(input int which, input logic [7:0] d, input int low_stop, input bit flip);
    logic [15:0] fb;
    int f;
    f  = (which == 1) ? F1 : F2;
    fb = frame_bits(d, (which == 1) ? 1 : 2, (which == 1), flip, low_stop);
    for (int i = 0; i < f; i++) begin
      if (which == 1) ext1 = fb[i];
      else            rx2  = fb[i];
      repeat (C) tick();
    end
    ext1 = 1'b1;
    rx2  = 1'b1;
    repeat (C) tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] w[10];
    logic [7:0] rw;
    int base, idx, n;
    logic r;

    rst_n = 1'b0;
    loop  = 1'b1;
    ext1  = 1'b1;
    rx2   = 1'b1;
    b1.tx_valid = 1'b1;
    b1.tx_data  = 8'h77;
    b2.tx_valid = 1'b0;
    b2.tx_data  = 8'h00;
    repeat (3) tick();

    chk("rst_tx", tx1, 1);
    chk("rst_tx_ready", b1.tx_ready, 1);
    chk("rst_tx_done", b1.tx_done, 0);
    chk("rst_rx_data", b1.rx_data, 0);
    chk("rst_rx_valid", b1.rx_valid, 0);
    chk("rst_frame_err", b1.rx_frame_err, 0);
    chk("rst_parity_err", b1.rx_parity_err, 0);
    chk("rst_u2_rx_data", b2.rx_data, 0);
    chk("rst_u2_frame_err", b2.rx_frame_err, 0);

    b1.tx_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;

    // Loopback 0xA5
    base = done_cnt;
    send1(8'hA5);
    wait_rx(1, 1, 400, "a5_count");
    chk("a5_word", pop(1), {2'b00, 8'hA5});
    repeat (40) tick();
    chk("a5_done_pulses", done_cnt - base, 1);
    chk("a5_single_valid", got1.size(), 0);
    chk("a5_done_position", mm_done, 0);

`ifdef UART_PARITY_EN
    send1(8'h0F);
    repeat (9 * C + C / 2) tick();
    chk("par_wire_bit", tx1, 1);
    wait_rx(1, 1, 400, "par_count");
    chk("par_word", pop(1), {2'b00, 8'h0F});
    repeat (40) tick();
    loop = 1'b0;
    drive(1, 8'h0F, -1, 1'b1);
    wait_rx(1, 1, 100, "parflip_count");
    chk("parflip_word", pop(1), {2'b10, 8'h0F});
    loop = 1'b1;
`endif

    // Two stop bits, second one low, then a clean frame
    drive(2, 8'h3C, 1, 1'b0);
    wait_rx(2, 1, 100, "stop2_count");
    chk("stop2_low_word", pop(2), {2'b01, 8'h3C});
    rw = 8'($urandom);
    drive(2, rw, -1, 1'b0);
    wait_rx(2, 1, 100, "stop2_clean_count");
    chk("stop2_clean_word", pop(2), {2'b00, rw});
    rw = 8'($urandom);
    drive(2, rw, 0, 1'b0);
    wait_rx(2, 1, 100, "stop1_low_count");
    chk("stop1_low_word", pop(2), {2'b01, rw});

    // Break: one frame error with zero data, then nothing until the line recovers
    rx2 = 1'b0;
    repeat (3 * F2 * C) tick();
    rx2 = 1'b1;
    chk("break_count", got2.size(), 1);
    chk("break_word", pop(2), {2'b01, 8'h00});
    repeat (C) tick();
    rw = 8'($urandom);
    drive(2, rw, -1, 1'b0);
    wait_rx(2, 1, 100, "after_break_count");
    chk("after_break_word", pop(2), {2'b00, rw});

    // Short low glitch is a false start
    loop = 1'b0;
    ext1 = 1'b0;
    repeat (3) tick();
    ext1 = 1'b1;
    repeat (3 * C) tick();
    chk("glitch_no_valid", got1.size(), 0);
    rw = 8'($urandom);
    drive(1, rw, -1, 1'b0);
    wait_rx(1, 1, 100, "glitch_next_count");
    chk("glitch_next_word", pop(1), {2'b00, rw});
    loop = 1'b1;
    repeat (C) tick();

    // Back-to-back with tx_valid held high
    for (int i = 0; i < 10; i++) w[i] = 8'($urandom_range(200, 10));
    got1.delete();
    base = hs_cnt;
    b1.tx_valid = 1'b1;
    b1.tx_data  = w[0];
    idx = 0;
    n = 0;
    while (idx < 10 && n < 4000) begin
      r = b1.tx_ready;
      tick();
      n++;
      if (r) begin
        idx++;
        if (idx < 10) b1.tx_data = w[idx];
      end
    end
    b1.tx_valid = 1'b0;
    chk("b2b_handshakes", hs_cnt - base, 10);
    chk("b2b_cycles", n, 1 + 9 * (F1 * C + 1));
    wait_rx(1, 10, 400, "b2b_count");
    for (int i = 0; i < 10; i++) chk($sformatf("b2b_word%0d", i), pop(1), {2'b00, w[i]});
    repeat (40) tick();

    // Reset in the middle of the data bits of 0x55
    got1.delete();
    base = done_cnt;
    send1(8'h55);
    repeat (4 * C) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_tx_high", tx1, 1);
    repeat (F1 * C + 20) tick();
    chk("rst_mid_no_valid", got1.size(), 0);
    chk("rst_mid_no_done", done_cnt - base, 0);
    send1(8'hC3);
    wait_rx(1, 1, 400, "c3_count");
    chk("c3_word", pop(1), {2'b00, 8'hC3});
    repeat (40) tick();

    chk("tx_waveform", mm_tx, 0);
    chk("tx_done_timing", mm_done, 0);
    chk("tx_ready_timing", mm_rdy, 0);
    chk("pulse_stretch", stretch, 0);
    chk("u2_tx_idle", tx2, 1);
    chk("u2_tx_ready", b2.tx_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_param.md
# uart_param

Parametrised full-duplex UART: the next generation of the team's fixed-format 8N1 UART. It adds configurable data width, stop bits and clocks-per-bit, a valid/ready transmit handshake, and receive framing/parity error flags. It sits between a byte-stream client and the serial pins, and also runs with `tx` looped back to `rx` for self-test.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; must be ≥ 4.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only when `UART_PARITY_EN` is defined.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `tx_valid` in 1: transmit request.
- `tx_data` in DATA_W: word to send. Sampled on the handshake.
- `tx_ready` out 1: transmitter is idle and can accept a word.
- `tx_done` out 1: one-cycle pulse in the final cycle of the last stop bit.
- `tx` out 1: serial output. Idles high.
- `rx` in 1: asynchronous serial input.
- `rx_data` out DATA_W: last received word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` and the error flags update.
- `rx_frame_err` out 1: a stop bit was sampled low. Valid with `rx_valid`.
- `rx_parity_err` out 1: parity mismatch. Valid with `rx_valid`. Constant 0 without `UART_PARITY_EN`.

## Operation
- Frame format: start (0), data LSB first, optional parity, STOP_BITS × 1. Every bit lasts `CLKS_PER_BIT` cycles.
- P denotes the parity bit count (1 or 0). Frame length is F = 1 + DATA_W + P + STOP_BITS bits.
- Transmitter FSM: IDLE → START → DATA → PARITY (only if enabled) → STOP → IDLE.
  - A bit counter holds the data index (0..DATA_W-1) and the stop index.
  - A baud counter runs 0..CLKS_PER_BIT-1.
  - `tx_ready` = (state == IDLE).
  - A handshake is `tx_valid && tx_ready` at a rising edge. It latches `tx_data` into the shift register.
  - `tx_data` changes after acceptance do not affect the frame in flight.
- Receiver:
  - `rx` passes through a 2-flop synchroniser.
  - Start detect is a high→low transition of the synchronised signal while in RX_IDLE.
  - RX_START waits `CLKS_PER_BIT/2` cycles, then resamples. If high, it is a false start and the FSM returns to RX_IDLE with no output.
  - Each later bit is sampled every `CLKS_PER_BIT` cycles, i.e. at mid-bit.
  - All STOP_BITS stop bits are checked. Any low stop sample sets `rx_frame_err`.
  - After the last stop-bit sample: `rx_data`, both error flags and `rx_valid` update on the same edge, then the FSM returns to RX_IDLE.
  - Data is delivered even on error.
- Line held low (break): reported as a frame error with `rx_data` = 0. No new start is detected until `rx` returns high and falls again.
- Transmitter and receiver are fully independent; simultaneous activity is legal.

## Timing
- Reset values:
  - `tx` = 1, `tx_ready` = 1, `tx_done` = 0.
  - `rx_data` = 0, `rx_valid` = 0, `rx_frame_err` = 0, `rx_parity_err` = 0.
  - Both FSMs go to IDLE.
  - Handshakes are ignored while `rst_n` = 0.
- Handshake at edge T: `tx` falls at T+1. The frame occupies cycles T+1 .. T+F·CLKS_PER_BIT. `tx_done` is high in the last of those cycles. `tx_ready` is 1 in the following cycle.
- Back-to-back: with `tx_valid` held high, the next handshake occurs on the first cycle `tx_ready` is 1. The gap is exactly 1 cycle of idle-high.
- Receiver: `rx_valid` is asserted 2 (sync) + 1 (edge) + CLKS_PER_BIT/2 + (F−1)·CLKS_PER_BIT cycles after the `rx` falling edge, ±1 cycle.
- Reset mid-frame:
  - `tx` goes high at the reset edge.
  - No `tx_done` or `rx_valid` is produced for the aborted frame.
  - The receiver ignores the remainder until the next valid start.
- `rx_valid` and `tx_done` are never stretched beyond 1 cycle.

## Configuration
- `UART_PARITY_EN` defined:
  - One parity bit is inserted after the data bits: XOR of the data, XORed with `PARITY_ODD`.
  - The receiver checks it and drives `rx_parity_err`.
- Not defined:
  - No parity bit is sent or expected, so F shrinks by 1.
  - `rx_parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.

## Test plan
- Loopback, DATA_W=8, CLKS_PER_BIT=16, STOP_BITS=1, no parity. Send 0xA5 → `rx_data`=0xA5, `rx_valid` pulses once, both error flags 0. `tx_done` pulses 160 cycles after the handshake.
- Loopback, `UART_PARITY_EN`, PARITY_ODD=1. Send 0x0F → parity bit on the wire is 1, `rx_parity_err`=0. Drive `rx` externally with the parity bit flipped → `rx_parity_err`=1 and `rx_data`=0x0F.
- External `rx`, STOP_BITS=2. Send 0x3C with the second stop bit driven low → `rx_frame_err`=1, `rx_data`=0x3C. A following clean frame clears the flag.
- `rx` low glitch of 3 cycles (CLKS_PER_BIT=16) → no `rx_valid`; the receiver is back in idle and accepts the next frame correctly.
- `tx_valid` held high with 10 random words in 10..200, DATA_W=8, loopback → 10 `rx_valid` pulses with matching data. Exactly 1 idle cycle between frames on `tx`.
- `rst_n` pulled low for 1 cycle in the middle of the data bits of 0x55 → `tx`=1 next cycle, no `tx_done`, no `rx_valid`. A subsequent 0xC3 transfer is received intact.
